// File: rtl/gpio_in_pkg.sv
// Shared register addresses, bus request bundle and popcount helper for gpio_in_capture.
package gpio_in_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ADDR_LEVEL = 3'd0;
  localparam logic [2:0] ADDR_RISE  = 3'd1;
  localparam logic [2:0] ADDR_FALL  = 3'd2;
  localparam logic [2:0] ADDR_MASK  = 3'd3;
  localparam logic [2:0] ADDR_EVCNT = 3'd4;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic [2:0]        addr;
    logic [DATA_W-1:0] dat;
  } bus_req_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) begin
      c = c + {5'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/gpio_debounce_bit.sv
// Purpose: 2-flop synchronizer plus debounce counter and stable-level flop for one input bit.
// Latency: raw edge reaches level after DEBOUNCE_CYCLES+2 cycles; shorter glitches are dropped.
// Backpressure: none, free-running.
module gpio_debounce_bit #(
  parameter  int DEBOUNCE_CYCLES = 100000,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], raw};
      if (sync_q[1] == level) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_MAX) begin
        level <= sync_q[1];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/gpio_in_capture.sv
// Purpose: debounced GPIO inputs with edge events, irq mask and optional EVCNT (GPIO_IN_EVCNT_EN).
// Latency: register reads return one cycle after rd_en; irq follows events/clears/mask by one cycle.
// Backpressure: none; rd_valid is a single-cycle pulse the core must take.
module gpio_in_capture
  import gpio_in_pkg::*;
#(
  parameter int N_IN            = 8,
  parameter int DEBOUNCE_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   raw_in,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [2:0]        addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              irq
);

  bus_req_t          req;
  logic [N_IN-1:0]   level;
  logic [N_IN-1:0]   level_q;
  logic [N_IN-1:0]   rise_ev;
  logic [N_IN-1:0]   fall_ev;
  logic [N_IN-1:0]   rise_q;
  logic [N_IN-1:0]   fall_q;
  logic [N_IN-1:0]   mask_q;
  logic [DATA_W-1:0] rd_mux;
  logic              rd_rise;
  logic              rd_fall;
  logic              wr_mask;
  logic              unused_wr_dat;

  assign req = '{rd: rd_en, wr: wr_en, addr: addr, dat: wr_data};
  assign unused_wr_dat = ^req.dat;

  for (genvar i = 0; i < N_IN; i++) begin : g_bit
    gpio_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_in[i]),
      .level(level[i])
    );
  end

  assign rise_ev = level & ~level_q;
  assign fall_ev = ~level & level_q;
  assign rd_rise = req.rd && (req.addr == ADDR_RISE);
  assign rd_fall = req.rd && (req.addr == ADDR_FALL);
  assign wr_mask = req.wr && (req.addr == ADDR_MASK);

`ifdef GPIO_IN_EVCNT_EN
  logic [DATA_W-1:0] evcnt_q;
  logic [31:0]       ev_chg;
  logic [5:0]        ev_inc;
  logic [32:0]       ev_sum;
  logic              rd_evcnt;

  always_comb begin
    ev_chg = '0;
    ev_chg[N_IN-1:0] = rise_ev | fall_ev;
  end

  assign ev_inc   = popcount32(ev_chg);
  assign ev_sum   = {1'b0, evcnt_q} + {27'd0, ev_inc};
  assign rd_evcnt = req.rd && (req.addr == ADDR_EVCNT);

  // The clearing read still keeps this cycle's increment so no change is lost.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      evcnt_q <= '0;
    end else if (rd_evcnt) begin
      evcnt_q <= {26'd0, ev_inc};
    end else begin
      evcnt_q <= ev_sum[32] ? '1 : ev_sum[31:0];
    end
  end
`endif

  always_comb begin
    rd_mux = '0;
    case (req.addr)
      ADDR_LEVEL: rd_mux[N_IN-1:0] = level;
      ADDR_RISE:  rd_mux[N_IN-1:0] = rise_q;
      ADDR_FALL:  rd_mux[N_IN-1:0] = fall_q;
      ADDR_MASK:  rd_mux[N_IN-1:0] = mask_q;
`ifdef GPIO_IN_EVCNT_EN
      ADDR_EVCNT: rd_mux = evcnt_q;
`endif
      default: ;
    endcase
  end

  // A read returns every pending bit, so clearing leaves only events landing this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q  <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      mask_q   <= '0;
      irq      <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      level_q  <= level;
      rise_q   <= rd_rise ? rise_ev : (rise_q | rise_ev);
      fall_q   <= rd_fall ? fall_ev : (fall_q | fall_ev);
      irq      <= |((rise_q | fall_q) & mask_q);
      rd_valid <= req.rd;
      if (wr_mask) begin
        mask_q <= req.dat[N_IN-1:0];
      end
      if (req.rd) begin
        rd_data <= rd_mux;
      end
    end
  end

endmodule
